// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampling UART receiver with configurable framing and a show-ahead receive FIFO.
module uart_rx_param #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int CLK_DIV    = 7,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rx,
  input  logic                          rd_en,
  input  logic                          err_clr,
  output logic [DATA_BITS-1:0]          d_out,
  output logic                          par_err,
  output logic                          frm_err,
  output logic                          rx_empty,
  output logic                          rx_full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overrun
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int NW = $clog2(DATA_BITS);
  localparam int WW = DATA_BITS + 2;
  localparam logic [DW-1:0] DMAX  = DW'(CLK_DIV - 1);
  localparam logic [SW-1:0] SHALF = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SFULL = SW'(OVERSAMPLE - 1);
  localparam logic [NW-1:0] NLAST = NW'(DATA_BITS - 1);
  localparam logic [NW-1:0] SLAST = NW'(STOP_BITS - 1);
  localparam logic [AW:0]   FULL  = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t               st;
  logic [1:0]           sync;
  logic [DW-1:0]        dc;
  logic [SW-1:0]        s;
  logic [NW-1:0]        n;
  logic [DATA_BITS-1:0] sh;
  logic                 pe, fe;
  logic [WW-1:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]        wp, rp;
  logic [WW-1:0]        word, head;
  logic                 rx_s, tick, mid, push, pop, wr;

  assign rx_s = sync[1];
  assign tick = dc == DMAX;
  assign mid  = tick && s == SFULL;
  assign push = st == STOP && mid && n == SLAST;
  assign word = {fe | ~rx_s, pe, sh};
  assign pop  = rd_en && !rx_empty;
  assign wr   = push && (!rx_full || pop);
  assign head = mem[rp];
  assign rx_empty = count == '0;
  assign rx_full  = count == FULL;
  assign d_out    = rx_empty ? '0 : head[DATA_BITS-1:0];
  assign par_err  = !rx_empty && head[DATA_BITS];
  assign frm_err  = !rx_empty && head[DATA_BITS+1];

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      sync <= 2'b11;
      dc   <= '0;
    end else begin
      sync <= {sync[0], rx};
      dc   <= tick ? '0 : dc + 1'b1;
    end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      st <= IDLE;
      s  <= '0;
      n  <= '0;
      sh <= '0;
      pe <= 1'b0;
      fe <= 1'b0;
    end else begin
      case (st)
        IDLE: if (!rx_s) begin
          st <= START;
          s  <= '0;
          n  <= '0;
          pe <= 1'b0;
          fe <= 1'b0;
        end
        START: if (tick) begin
          s <= s + 1'b1;
          if (s == SHALF) begin
            st <= rx_s ? IDLE : DATA;
            s  <= '0;
          end
        end
        DATA: if (tick) begin
          s <= s + 1'b1;
          if (mid) begin
            s  <= '0;
            sh <= {rx_s, sh[DATA_BITS-1:1]};
            n  <= n + 1'b1;
            if (n == NLAST) begin
              n  <= '0;
              st <= PARITY != 0 ? PAR : STOP;
            end
          end
        end
        PAR: if (tick) begin
          s <= s + 1'b1;
          if (mid) begin
            s  <= '0;
            pe <= (^sh ^ rx_s) ^ (PARITY == 1);
            st <= STOP;
          end
        end
        STOP: if (tick) begin
          s <= s + 1'b1;
          if (mid) begin
            s  <= '0;
            fe <= fe | ~rx_s;
            n  <= n + 1'b1;
            if (n == SLAST) st <= IDLE;
          end
        end
        default: st <= IDLE;
      endcase
    end

  always_ff @(posedge clk)
    if (wr) mem[wp] <= word;

  // A push into a full FIFO only lands when the same cycle frees a slot.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wp      <= '0;
      rp      <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      count   <= wr && !pop ? count + 1'b1 : !wr && pop ? count - 1'b1 : count;
      overrun <= push && !wr ? 1'b1 : err_clr ? 1'b0 : overrun;
    end
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed checks of 8N1, even-parity and depth-4 receiver instances.
module tb_uart_rx_param;
  localparam int BP = 112;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] rxv = 3'b111;
  logic [2:0] rd = '0;
  logic [2:0] ec = '0;
  int         checks = 0;
  int         errors = 0;

  logic [7:0] d0, d1, d2;
  logic [2:0] pe, fe, emp, ful, ovr;
  logic [4:0] cnt0, cnt1;
  logic [2:0] cnt2;

  always #5 clk = ~clk;

  uart_rx_param u0 (.clk(clk), .reset(reset), .rx(rxv[0]), .rd_en(rd[0]), .err_clr(ec[0]),
    .d_out(d0), .par_err(pe[0]), .frm_err(fe[0]), .rx_empty(emp[0]), .rx_full(ful[0]),
    .count(cnt0), .overrun(ovr[0]));
  uart_rx_param #(.PARITY(2)) u1 (.clk(clk), .reset(reset), .rx(rxv[1]), .rd_en(rd[1]), .err_clr(ec[1]),
    .d_out(d1), .par_err(pe[1]), .frm_err(fe[1]), .rx_empty(emp[1]), .rx_full(ful[1]),
    .count(cnt1), .overrun(ovr[1]));
  uart_rx_param #(.FIFO_DEPTH(4)) u2 (.clk(clk), .reset(reset), .rx(rxv[2]), .rd_en(rd[2]), .err_clr(ec[2]),
    .d_out(d2), .par_err(pe[2]), .frm_err(fe[2]), .rx_empty(emp[2]), .rx_full(ful[2]),
    .count(cnt2), .overrun(ovr[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic bit_time(input int sel, input logic v, input int len);
    rxv[sel] = v;
    repeat (len) @(negedge clk);
  endtask

  // A bad stop bit stays low past its midpoint sample, then returns high early so the
  // re-armed start detector sees a false start rather than a phantom frame.
  task automatic send(input int sel, input logic [7:0] d, input bit par, input logic pb, input bit stop_ok);
    bit_time(sel, 1'b0, BP);
    for (int i = 0; i < 8; i++) bit_time(sel, d[i], BP);
    if (par) bit_time(sel, pb, BP);
    if (stop_ok) bit_time(sel, 1'b1, BP);
    else begin
      bit_time(sel, 1'b0, 80);
      bit_time(sel, 1'b1, 32);
    end
    bit_time(sel, 1'b1, 2 * BP);
  endtask

  task automatic pulse_rd(input int sel);
    rd[sel] = 1'b1;
    @(negedge clk);
    rd[sel] = 1'b0;
  endtask

  initial begin
    repeat (4) @(negedge clk);
    check("rst_dout", d0, 0);
    check("rst_par", pe[0], 0);
    check("rst_frm", fe[0], 0);
    check("rst_empty", emp[0], 1);
    check("rst_full", ful[0], 0);
    check("rst_count", cnt0, 0);
    check("rst_ovr", ovr[0], 0);
    reset = 1'b1;
    repeat (20) @(negedge clk);

    send(0, 8'hA5, 0, 0, 1);
    check("a5_empty", emp[0], 0);
    check("a5_dout", d0, 8'hA5);
    check("a5_par", pe[0], 0);
    check("a5_frm", fe[0], 0);
    check("a5_count", cnt0, 1);
    pulse_rd(0);
    check("a5_pop_empty", emp[0], 1);
    check("a5_pop_dout", d0, 0);
    pulse_rd(0);
    check("rd_on_empty", cnt0, 0);

    send(1, 8'h03, 1, 1'b1, 1);
    check("par_bad_dout", d1, 8'h03);
    check("par_bad_flag", pe[1], 1);
    pulse_rd(1);
    send(1, 8'h03, 1, 1'b0, 1);
    check("par_ok_dout", d1, 8'h03);
    check("par_ok_flag", pe[1], 0);
    check("par_ok_count", cnt1, 1);
    pulse_rd(1);

    send(0, 8'h55, 0, 0, 0);
    check("frm_dout", d0, 8'h55);
    check("frm_flag", fe[0], 1);
    check("frm_count", cnt0, 1);
    pulse_rd(0);
    send(0, 8'h0F, 0, 0, 1);
    check("after_frm_dout", d0, 8'h0F);
    check("after_frm_flag", fe[0], 0);
    check("after_frm_count", cnt0, 1);
    pulse_rd(0);

    bit_time(0, 1'b0, 21);
    bit_time(0, 1'b1, 3 * BP);
    check("glitch_empty", emp[0], 1);
    check("glitch_count", cnt0, 0);

    for (int k = 0; k < 4; k++) send(2, 8'(8'h11 + k), 0, 0, 1);
    check("fifo_full", ful[2], 1);
    check("fifo_count4", cnt2, 4);
    check("fifo_no_ovr", ovr[2], 0);
    send(2, 8'h15, 0, 0, 1);
    check("fifo_ovr", ovr[2], 1);
    check("fifo_count_keep", cnt2, 4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("fifo_pop%0d", k), d2, 8'(8'h11 + k));
      pulse_rd(2);
    end
    check("fifo_drained", emp[2], 1);
    check("ovr_sticky", ovr[2], 1);
    ec[2] = 1'b1;
    @(negedge clk);
    ec[2] = 1'b0;
    check("ovr_clr", ovr[2], 0);

    send(0, 8'h77, 0, 0, 1);
    check("pre_rst_count", cnt0, 1);
    bit_time(0, 1'b0, BP);
    for (int i = 0; i < 4; i++) bit_time(0, i[0], BP);
    reset = 1'b0;
    rxv[0] = 1'b1;
    #1;
    check("midrst_empty", emp[0], 1);
    check("midrst_count", cnt0, 0);
    check("midrst_dout", d0, 0);
    check("midrst_full", ful[0], 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2 * BP) @(negedge clk);
    check("post_rst_idle", emp[0], 1);
    send(0, 8'h3C, 0, 0, 1);
    check("post_rst_count", cnt0, 1);
    check("post_rst_dout", d0, 8'h3C);
    check("post_rst_par", pe[0], 0);
    check("post_rst_frm", fe[0], 0);
    pulse_rd(0);
    check("post_rst_empty", emp[0], 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL timeout got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised successor to the team's fixed 8N1 UART receiver. It adds configurable data width, parity, stop bits, an internal oversampling baud tick and a configurable-depth receive FIFO. Each word carries its own parity and framing error flags, and a sticky overrun flag is provided. The block sits between the pad-side serial `rx` line and the bus-side reader, which drains it through `rd_en`/`d_out`/`rx_empty` exactly as with the previous receiver.

Parameters:
DATA_BITS, 8, data bits per frame (5..9), LSB first
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, stop bits checked (1 or 2)
CLK_DIV, 7, clk cycles per oversample tick
OVERSAMPLE, 16, ticks per bit period (even, >= 8)
FIFO_DEPTH, 16, receive FIFO entries (power of 2, >= 2)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
rx  in  1  serial input, idle high, asynchronous to clk
rd_en  in  1  pop head of FIFO this cycle
err_clr  in  1  clears sticky overrun
d_out  out  DATA_BITS  FIFO head data; 0 when rx_empty=1
par_err  out  1  parity error flag of head word (0 when empty or PARITY=0)
frm_err  out  1  framing error flag of head word (0 when empty)
rx_empty  out  1  FIFO empty
rx_full  out  1  FIFO full
count  out  $clog2(FIFO_DEPTH)+1  words held
overrun  out  1  sticky: a completed word was dropped because the FIFO was full

Behaviour:
- Reset (reset=0, asynchronous): FSM=IDLE; tick and bit counters 0; synchroniser flops 1; FIFO pointers 0. Outputs: d_out=0, par_err=0, frm_err=0, rx_empty=1, rx_full=0, count=0, overrun=0. Reset mid-frame discards the partial frame.
- rx passes through a 2-flop synchroniser (rx_s) initialised to 1. All decisions use rx_s.
- Tick generator: free-running counter 0..CLK_DIV-1. tick=1 for one clk when the counter equals CLK_DIV-1.
- FSM states: IDLE, START, DATA, PARITY, STOP. s = tick count, n = bit index.
- IDLE: when rx_s=0, go to START with s=0.
- START: s increments on each tick. At the tick where s=OVERSAMPLE/2-1:
  - rx_s=0: go to DATA with s=0, n=0.
  - rx_s=1: false start (glitch); return to IDLE and push nothing.
- DATA: on the tick where s=OVERSAMPLE-1, shift rx_s into bit n (LSB first) and set s=0. After bit DATA_BITS-1, go to PARITY if PARITY≠0, otherwise STOP.
- PARITY: sample at the same point. par_err = XOR(data, parity bit) mismatches the expected value (odd: total XOR must be 1; even: total XOR must be 0).
- STOP: sample each stop bit at the same point. Any sampled 0 sets frm_err for the word.
  - After the last stop-bit sample, push {frm_err, par_err, data} in the same clk and return to IDLE, so a back-to-back start bit is detected from the stop-bit midpoint onward.
  - Words with errors are still pushed, flagged.
- FIFO, show-ahead: d_out, par_err and frm_err reflect the head combinationally whenever rx_empty=0.
  - Pop on rd_en=1 && rx_empty=0. rd_en while empty is ignored, with no pointer change.
  - Push while full with no pop in the same cycle: the word is dropped, FIFO contents are unchanged, overrun is set.
  - Push and pop in the same cycle while full: both occur; count unchanged, no overrun.
  - Push and pop in the same cycle while non-empty: count unchanged.
  - Pointers wrap modulo FIFO_DEPTH. rx_full = (count == FIFO_DEPTH).
- Flag timing: rx_empty, count and rx_full update on the clk edge after the push/pop edge (registered count).
- overrun: set by a drop and cleared by err_clr. If both happen in the same cycle, set wins.
- Latency: from the rx pin falling edge, a word is readable OVERSAMPLE×CLK_DIV×(DATA_BITS + (PARITY≠0) + STOP_BITS + 0.5) clk cycles later, ±(CLK_DIV+2) clk.

Test Plan:
- 8N1, default parameters (bit period 112 clk), send 0xA5 → rx_empty falls; d_out=0xA5, par_err=0, frm_err=0, count=1. Pulse rd_en for 1 clk → rx_empty=1, d_out=0.
- PARITY=2, send 0x03 with parity bit 1 → d_out=0x03, par_err=1. Resend with parity bit 0 → par_err=0.
- Send 0x55 with stop bit driven 0 → word pushed; d_out=0x55, frm_err=1. A following valid 0x0F is received cleanly.
- Drive rx low for 3 ticks (21 clk), then high → FSM returns to IDLE; rx_empty stays 1, count=0.
- FIFO_DEPTH=4, send 5 frames (0x11..0x15) with no reads → rx_full=1 after the 4th, overrun=1 after the 5th. Four pops return 0x11..0x14 in order. err_clr → overrun=0.
- Assert reset halfway through the DATA bits of a frame → all outputs at reset values. Deassert and send 0x3C → exactly one word, 0x3C, with no error flags.
